// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ write-domain producers.
// Grants one requester per packet burst, capped at MAX_BURST beats, and never writes while wr_full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                           wr_clk,
  input  logic                           wr_rstn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wr_full,
  output logic                           wr_inc,
  output logic [DATA_SIZE-1:0]           wr_data,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic [$clog2(MAX_BURST+1)-1:0] beat_cnt,
  output logic                           burst_cut
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              burst_cut_q, burst_cut_d;

  logic [ID_W-1:0]   winner;
  logic              winner_found;
  logic [ID_W-1:0]   next_ptr;
  logic              transfer;
  logic              at_cap;
  logic              is_last;

  // Index offset positions past base, wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                               input int unsigned     offset);
    int unsigned sum;
    sum = 32'(base) + offset;
    return ID_W'(sum % NUM_REQ);
  endfunction

  always_comb begin
    winner       = rr_ptr_q;
    winner_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!winner_found && req_valid[rr_index(rr_ptr_q, k)]) begin
        winner       = rr_index(rr_ptr_q, k);
        winner_found = 1'b1;
      end
    end
  end

  assign next_ptr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
  assign is_last  = req_last[grant_id_q];
  assign at_cap   = (beat_cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cut_d = 1'b0;
    req_ready   = '0;
    wr_inc      = 1'b0;
    wr_data     = '0;
    transfer    = 1'b0;

    case (state_q)
      IDLE: begin
        if (winner_found) begin
          state_d    = BURST;
          grant_id_d = winner;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        req_ready[grant_id_q] = !wr_full;
        transfer              = req_valid[grant_id_q] && !wr_full;
        wr_inc                = transfer;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id_q == ID_W'(i)) wr_data = req_data[i*DATA_SIZE +: DATA_SIZE];
        end
        if (transfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (is_last || at_cap) begin
            state_d     = IDLE;
            rr_ptr_d    = next_ptr;
            beat_cnt_d  = '0;
            burst_cut_d = !is_last;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      beat_cnt_q  <= '0;
      burst_cut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cut_q <= burst_cut_d;
    end
  end

  assign grant_id  = grant_id_q;
  assign busy      = (state_q == BURST);
  assign beat_cnt  = beat_cnt_q;
  assign burst_cut = burst_cut_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one async FIFO write side among NUM_REQ requesters in the write clock domain. It grants one requester at a time for a packet burst and drives the FIFO write strobe and data. It honours full back-pressure, so no write is ever attempted while the FIFO is full. It sits between the write-domain producers and the FIFO's wr_inc/wr_data/wr_full interface.

Parameters:
NUM_REQ, 4, number of requesters (min 2)
DATA_SIZE, 8, FIFO data width in bits
MAX_BURST, 16, maximum beats per grant before forced release (min 1)

Ports:
wr_clk  in  1  write-domain clock
wr_rstn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*DATA_SIZE  per-requester data; requester i uses bits [i*DATA_SIZE +: DATA_SIZE]
req_last  in  NUM_REQ  per-requester last beat of packet
req_ready  out  NUM_REQ  per-requester beat accepted (one-hot or zero)
wr_full  in  1  FIFO full flag
wr_inc  out  1  FIFO write strobe
wr_data  out  DATA_SIZE  FIFO write data
grant_id  out  $clog2(NUM_REQ)  currently granted requester
busy  out  1  high while in BURST state
beat_cnt  out  $clog2(MAX_BURST+1)  beats accepted in current grant
burst_cut  out  1  one-cycle pulse: grant released by MAX_BURST cap without last

Behaviour:
- Reset (asynchronous, immediate, also mid-burst) clears state to IDLE and rr_ptr, grant_id, beat_cnt, busy and burst_cut to 0. req_ready and wr_inc are 0 and wr_data is 0 while reset is asserted. A partially written packet is abandoned and no recovery is performed.
- States: IDLE, BURST.
- IDLE:
  - req_ready = 0, wr_inc = 0, wr_data = 0.
  - If any req_valid is high, the winner is the first valid index scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Next edge: grant_id <= winner, beat_cnt <= 0, state <= BURST.
  - Arbitration costs exactly one cycle. No data moves in IDLE.
- BURST:
  - req_ready[grant_id] = !wr_full; all other req_ready bits are 0.
  - Transfer = req_valid[grant_id] && !wr_full.
  - wr_inc = transfer; wr_data = req_data slice of grant_id (combinational, zero-latency pass-through). wr_data may be either the granted slice or 0 when wr_inc = 0.
  - On each transfer, beat_cnt increments.
  - Release when a transfer occurs with req_last[grant_id] = 1, or when a transfer makes beat_cnt reach MAX_BURST. On release:
    - state <= IDLE
    - rr_ptr <= (grant_id + 1) mod NUM_REQ
    - beat_cnt <= 0
  - If release is by cap and req_last = 0, burst_cut pulses high for the next cycle. If last arrives on the capping beat, there is no pulse.
  - If the granted requester deasserts valid mid-packet, the grant is held indefinitely (no timeout). Other requesters wait.
- busy = (state == BURST), registered.
- There is always at least one bubble cycle between consecutive grants, including a re-grant of the same requester.
- wr_full rising mid-burst: wr_inc and req_ready drop in the same cycle, and beat_cnt holds. Transfers resume when wr_full falls.
- A requester must hold valid, data and last stable until ready. Data on non-granted requesters is ignored.
- Fairness: with all requesters continuously valid, grants rotate 0, 1, 2, … NUM_REQ-1, 0.

Test Plan:
- Single requester 2 sends 3 beats (0xA1, 0xA2, 0xA3 with last) while other requesters are idle and wr_full = 0 -> one IDLE cycle, then 3 consecutive wr_inc pulses with wr_data 0xA1/0xA2/0xA3, grant_id = 2, then IDLE and rr_ptr = 3.
- All 4 requesters valid with 2-beat packets -> grant order 0, 1, 2, 3, 0, each grant separated by exactly one bubble cycle, 8 writes per full round.
- Requester 1 sends a 20-beat packet with MAX_BURST = 16 -> 16 writes, burst_cut pulses once, requester 2 is granted next, and requester 1 later receives the remaining 4 beats.
- wr_full asserted for 5 cycles after beat 2 of a 6-beat packet -> wr_inc = 0 and req_ready = 0 for those 5 cycles, beat_cnt holds at 2, and all 6 beats are written with no loss or duplication.
- wr_rstn asserted mid-burst at beat 3 -> all outputs go to 0 immediately. After release, a new request from requester 0 is arbitrated starting from rr_ptr = 0.
- Granted requester drops valid for 4 cycles mid-packet while requester 3 is valid -> grant is held, no writes occur, requester 3 stays unserved until the packet's last beat.
